// File: rtl/spart_bus_if_pkg.sv
// Shared SPART definitions: register map, status bit positions and the default baud divisor.
package spart_pkg;

    typedef enum logic [1:0] {
        DATA   = 2'b00,
        STATUS = 2'b01,
        DB_LO  = 2'b10,
        DB_HI  = 2'b11
    } ioaddr_e;

    localparam int STAT_TBR = 0;
    localparam int STAT_RDA = 1;
    localparam int STAT_OVR = 2;

    localparam logic [15:0] DEFAULT_DIVISOR = 16'd325;

    // A zero divisor is treated as one so the tick never stalls.
    function automatic logic [15:0] eff_divisor(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/spart_bus_if_if.sv
// Bus handshake of the SPART register block; the shared databus stays a top-level inout.
interface spart_io_if;
    logic       iocs;
    logic       iorw;
    logic [1:0] ioaddr;
    logic       rda;
    logic       tbr;

    modport master (output iocs, iorw, ioaddr, input rda, tbr);
    modport slave  (input iocs, iorw, ioaddr, output rda, tbr);
endinterface

// File: rtl/spart_bus_if_baud_gen.sv
// 16x oversample tick generator: down-counter that pulses baud_en on count 1 and reloads.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter logic [15:0] RESET_DIVISOR = DEFAULT_DIVISOR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] divisor,
    input  logic        load,
    output logic        baud_en
);
    logic [15:0] cnt;

    assign baud_en = (cnt == 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= RESET_DIVISOR;
        end else if (load || baud_en) begin
            cnt <= eff_divisor(divisor);
        end else begin
            cnt <= cnt - 16'd1;
        end
    end
endmodule

// File: rtl/spart_bus_if.sv
// SPART bus interface: register decode, TX holding register, RX storage and baud divisor.
// Define SPART_RX_FIFO_EN for an RX_DEPTH-entry receive FIFO; otherwise a single holding register.
module spart_bus_if
    import spart_pkg::*;
#(
    parameter logic [15:0] RESET_DIVISOR = DEFAULT_DIVISOR,
    parameter int          RX_DEPTH      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    spart_io_if.slave  bus,
    inout  wire  [7:0] databus,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       baud_en
);
    ioaddr_e     addr;
    logic        rd_acc;
    logic        wr_acc;
    logic [7:0]  rd_data;
    logic [15:0] div_q;
    logic [15:0] div_d;
    logic        db_load;
    logic        tx_full;
    logic        tx_wr;
    logic        ovr_q;
    logic        stat_rd;
    logic        rx_pop;
    logic        rx_push;
    logic        rx_drop;
    logic        rx_full;
    logic        rx_nonempty;
    logic [7:0]  rx_head;

    assign addr    = ioaddr_e'(bus.ioaddr);
    assign rd_acc  = bus.iocs & bus.iorw;
    assign wr_acc  = bus.iocs & ~bus.iorw;
    assign stat_rd = rd_acc && (addr == STATUS);
    assign rx_pop  = rd_acc && (addr == DATA) && rx_nonempty;
    assign rx_push = rx_valid && (!rx_full || rx_pop);
    assign rx_drop = rx_valid && rx_full && !rx_pop;

    assign bus.rda = rx_nonempty;
    assign bus.tbr = ~tx_full;

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            DATA:   rd_data = rx_nonempty ? rx_head : 8'h00;
            STATUS: begin
                rd_data[STAT_OVR] = ovr_q;
                rd_data[STAT_RDA] = rx_nonempty;
                rd_data[STAT_TBR] = ~tx_full;
            end
            DB_LO:  rd_data = div_q[7:0];
            default: rd_data = div_q[15:8];
        endcase
    end

    assign databus = rd_acc ? rd_data : 8'hzz;

    // The counter sees the post-write divisor so a DB high write reloads with the new value.
    always_comb begin
        div_d = div_q;
        if (wr_acc && (addr == DB_LO)) div_d[7:0]  = databus;
        if (wr_acc && (addr == DB_HI)) div_d[15:8] = databus;
    end

    assign db_load = wr_acc && (addr == DB_HI);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= RESET_DIVISOR;
        else        div_q <= div_d;
    end

    spart_baud_gen #(.RESET_DIVISOR(RESET_DIVISOR)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .divisor (div_d),
        .load    (db_load),
        .baud_en (baud_en)
    );

    assign tx_wr    = wr_acc && (addr == DATA) && !tx_full;
    assign tx_start = tx_full & ~tx_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_full <= 1'b0;
            tx_data <= 8'h00;
        end else if (tx_wr) begin
            tx_full <= 1'b1;
            tx_data <= databus;
        end else if (tx_start) begin
            tx_full <= 1'b0;
        end
    end

    // Set wins over the clearing status read so a coincident drop is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ovr_q <= 1'b0;
        else if (rx_drop) ovr_q <= 1'b1;
        else if (stat_rd) ovr_q <= 1'b0;
    end

`ifdef SPART_RX_FIFO_EN
    localparam int PTR_W = (RX_DEPTH > 1) ? $clog2(RX_DEPTH) : 1;

    logic [7:0]       rx_mem [RX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   rx_cnt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RX_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign rx_full     = (rx_cnt == (PTR_W+1)'(RX_DEPTH));
    assign rx_nonempty = (rx_cnt != '0);
    assign rx_head     = rx_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rx_cnt <= '0;
        end else begin
            if (rx_push) wr_ptr <= ptr_inc(wr_ptr);
            if (rx_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
            else if (rx_pop && !rx_push) rx_cnt <= rx_cnt - 1'b1;
        end
    end
`else
    logic [7:0] rx_hold;
    logic       rx_vld;
    wire [31:0] rx_depth_unused = 32'(RX_DEPTH);

    assign rx_full     = rx_vld;
    assign rx_nonempty = rx_vld;
    assign rx_head     = rx_hold;

    always_ff @(posedge clk) begin
        if (rx_push) rx_hold <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       rx_vld <= 1'b0;
        else if (rx_push) rx_vld <= 1'b1;
        else if (rx_pop)  rx_vld <= 1'b0;
    end
`endif

endmodule

// File: doc/spart_bus_if.md
SPART_BUS_IF -- requirements
Module: spart_bus_if

Interface
REQ-001 Parameter RESET_DIVISOR, default 16'd325, SHALL set the baud divisor loaded at reset (16x oversample tick period in clk cycles).
REQ-002 Parameter RX_DEPTH, default 4, SHALL set the RX FIFO entries; it is used only when SPART_RX_FIFO_EN is defined and is a power of two.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge.
REQ-004 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-005 iocs  input  1  SHALL be the bus chip select from the driver.
REQ-006 iorw  input  1  SHALL be the access direction: 1 read, 0 write.
REQ-007 ioaddr  input  2  SHALL be the register select: 00 data, 01 status, 10 DB low, 11 DB high.
REQ-008 databus  inout  8  SHALL be the shared bidirectional data bus.
REQ-009 rda  output  1  SHALL flag that receive data is available.
REQ-010 tbr  output  1  SHALL flag that the transmit buffer is ready.
REQ-011 tx_data  output  8, tx_start  output  1  SHALL carry the byte and a 1-cycle launch pulse to the transmitter.
REQ-012 tx_busy  input  1  SHALL indicate that the transmitter is shifting.
REQ-013 rx_data  input  8, rx_valid  input  1  SHALL carry a received byte, with rx_valid a 1-cycle pulse.
REQ-014 baud_en  output  1  SHALL be a 1-cycle 16x baud tick to the TX/RX shifters.

Function
REQ-015 databus SHALL be driven only while iocs=1 and iorw=1; otherwise it is high-Z.
REQ-016 Reads SHALL be combinational in the same cycle: 00 = RX head byte (0x00 if empty); 01 = {5'b0, overrun, rda, tbr}; 10/11 = divisor low/high byte.
REQ-017 Writes (iocs=1, iorw=0) SHALL be sampled at posedge: 00 = TX byte; 10/11 = divisor byte; 01 = ignored.
REQ-018 A write to DB high SHALL reload the baud counter at that edge; a write to DB low SHALL take effect at the next reload.
REQ-019 Baud counter: a 16-bit down-counter; baud_en=1 for one cycle when the count is 1, followed by a reload; period = divisor cycles; divisor 0 SHALL behave as 1 (baud_en every cycle).
REQ-020 TX holding register: a write to 00 with tbr=1 SHALL latch the byte and drive tbr=0 on the next cycle; a write with tbr=0 SHALL be dropped with no state change.
REQ-021 TX handoff: while the holding register is full and tx_busy=0, tx_start=1 for exactly one cycle with tx_data valid; tbr=1 on the following cycle.
REQ-022 TX latency: a write at edge N SHALL give tx_start high in cycle N..N+1 and tbr=1 at N+2, provided tx_busy=0.
REQ-023 RX: rx_valid SHALL push rx_data; rda=1 whenever storage is non-empty; a read of 00 SHALL pop at that edge; a read of 00 while empty SHALL change no state.
REQ-024 Overrun: rx_valid while storage is full SHALL discard the byte and set the sticky overrun bit; a status read SHALL clear overrun at that edge.
REQ-025 Simultaneous push and pop while full SHALL both occur, with no overrun and occupancy unchanged.
REQ-026 Simultaneous overrun and status read SHALL leave overrun=1.
REQ-027 FIFO pointers SHALL wrap modulo RX_DEPTH.

Reset
REQ-028 While rst_n=0: tbr=1, rda=0, overrun=0, tx_start=0, tx_data=0x00, baud_en=0, divisor=RESET_DIVISOR, counter=RESET_DIVISOR, RX storage emptied, databus high-Z.
REQ-029 Reset mid-transfer SHALL discard pending TX/RX bytes without emitting tx_start.

Configuration
REQ-030 With SPART_RX_FIFO_EN defined, RX storage SHALL be an RX_DEPTH-entry FIFO; without it, RX storage SHALL be a single 8-bit holding register (depth 1) with identical rda/overrun/pop rules.

Structure
REQ-031 Package spart_pkg SHALL hold the ioaddr enum (DATA, STATUS, DB_LO, DB_HI), the status bit indices, and the default divisor constant.
REQ-032 The baud counter SHALL be sub-module spart_baud_gen (inputs divisor and load; output baud_en).

Verification
REQ-033 Reset then read 01 -> databus 0x01; read 10/11 -> 0x45/0x01.
REQ-034 Write 0x55 to 00 with tx_busy=0 -> tbr=0 next cycle, one tx_start with tx_data=0x55, tbr=1 two cycles after the write; a second write while tbr=0 is dropped.
REQ-035 Write DB low 0x04 then DB high 0x00 -> baud_en pulses exactly every 4 cycles from the DB-high edge; divisor 0 -> baud_en every cycle.
REQ-036 FIFO build: push 0x11,0x22,0x33,0x44,0x99 -> rda=1, status 0x07, reads of 00 return 0x11..0x44 then 0x00; status read then clears overrun (status 0x01). Non-FIFO build: push 0x11,0x22 -> read 0x11, overrun=1.
REQ-037 With storage full, rx_valid coincident with a read of 00 -> popped byte returned, overrun stays 0, rda stays 1.
REQ-038 Assert rst_n=0 with TX full and tx_busy=1 -> no tx_start; after release tbr=1, rda=0, databus high-Z when iocs=0.
